// File: rtl/color_pkg.sv
// rtl/color_pkg.sv - shared types, defaults and palette lookup for the colour sequencer
package color_pkg;

    localparam int CNT_W_DEF  = 25;
    localparam int CHAN_W_DEF = 4;
    localparam int MAX_DEF    = (1 << CHAN_W_DEF) - 1;

    typedef enum logic [1:0] {
        BLINK   = 2'd0,
        PALETTE = 2'd1,
        FADE    = 2'd2,
        HOLD    = 2'd3
    } mode_e;

    // One bit per channel: channel is fully on when set, off otherwise.
    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_on_t;

    function automatic rgb_on_t palette(input logic [2:0] idx);
        rgb_on_t c;
        c.r = idx[0];
        c.g = idx[1];
        c.b = idx[2];
        return c;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - programmable step generator with period+1 spacing and synchronous clear
module tick_prescaler #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] period,
    output logic             fire,
    output logic             step
);

    logic [CNT_W-1:0] cnt;

    // fire is the step about to be registered; the top updates colour on the same edge.
    assign fire = enable && !clear && (cnt >= period);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt  <= '0;
            step <= 1'b0;
        end else if (enable) begin
            if (cnt >= period) begin
                cnt  <= '0;
                step <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                step <= 1'b0;
            end
        end else begin
            step <= 1'b0;
        end
    end

endmodule

// File: rtl/color_sequencer.sv
// rtl/color_sequencer.sv - four-mode RGB test colour sequencer driven by a programmable step rate
module color_sequencer
    import color_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int CHAN_W = CHAN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  period,
    output logic              step,
    output logic [CHAN_W-1:0] red,
    output logic [CHAN_W-1:0] green,
    output logic [CHAN_W-1:0] blue
);

    localparam logic [CHAN_W-1:0] MAX = '1;

    mode_e             mode_q;
    logic              change;
    logic              fire;
    logic [2:0]        idx;
    logic [2:0]        idx_nxt;
    logic [CHAN_W-1:0] level;
    logic [CHAN_W-1:0] level_nxt;
    logic              dir_down;
    logic              dir_down_nxt;
    rgb_on_t           pal;

    assign change = (mode_e'(mode) != mode_q);

    tick_prescaler #(.CNT_W(CNT_W)) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (change),
        .period (period),
        .fire   (fire),
        .step   (step)
    );

    // Triangle walker: each end holds for one extra step while direction flips.
    always_comb begin
        level_nxt    = level;
        dir_down_nxt = dir_down;
        idx_nxt      = idx + 3'd1;
        pal          = palette(idx_nxt);
        if (!dir_down) begin
            if (level == MAX) dir_down_nxt = 1'b1;
            else              level_nxt    = level + 1'b1;
        end else begin
            if (level == '0)  dir_down_nxt = 1'b0;
            else              level_nxt    = level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q   <= BLINK;
            idx      <= '0;
            level    <= '0;
            dir_down <= 1'b0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
        end else if (change) begin
            mode_q   <= mode_e'(mode);
            idx      <= '0;
            level    <= '0;
            dir_down <= 1'b0;
            red      <= '0;
            green    <= (mode_e'(mode) == FADE) ? MAX : '0;
            blue     <= '0;
        end else if (fire) begin
            case (mode_q)
                BLINK: begin
                    red  <= ~red;
                    blue <= ~blue;
                end
                PALETTE: begin
                    idx   <= idx_nxt;
                    red   <= {CHAN_W{pal.r}};
                    green <= {CHAN_W{pal.g}};
                    blue  <= {CHAN_W{pal.b}};
                end
                FADE: begin
                    level    <= level_nxt;
                    dir_down <= dir_down_nxt;
                    red      <= level_nxt;
                    green    <= MAX - level_nxt;
                    blue     <= '0;
                end
                HOLD: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule
